// File: rtl/sprite_pixel_engine_pkg.sv
// Shared action codes, FSM state type and helpers for the sprite pixel engine.
package sprite_pixel_engine_pkg;

  localparam logic [2:0] ACT_STAY  = 3'd0;
  localparam logic [2:0] ACT_FWD   = 3'd1;
  localparam logic [2:0] ACT_BACK  = 3'd2;
  localparam logic [2:0] ACT_PUNCH = 3'd3;
  localparam logic [2:0] ACT_KICK  = 3'd4;

  localparam int FRM_W = 3;

  typedef enum logic {ST_LOOP, ST_ONESHOT} st_e;

  function automatic logic is_oneshot(input int a);
    return (a == int'(ACT_PUNCH)) || (a == int'(ACT_KICK));
  endfunction

endpackage

// File: rtl/sprite_pixel_engine_if.sv
// VGA pixel stream: coordinates in from the timing generator, colour/opacity out to the mixer.
interface sprite_pixel_engine_if #(parameter int CHANNELS = 3);
  logic [9:0]          pix_x;
  logic [9:0]          pix_y;
  logic                pix_in_vld;
  logic [CHANNELS-1:0] pix_rgb;
  logic                pix_opaque;
  logic                pix_out_vld;

  modport master (output pix_x, pix_y, pix_in_vld, input pix_rgb, pix_opaque, pix_out_vld);
  modport slave  (input pix_x, pix_y, pix_in_vld, output pix_rgb, pix_opaque, pix_out_vld);
endinterface

// File: rtl/sprite_pixel_engine_rom.sv
// One colour channel of the sprite bitmap: registered row lookup, MSB = leftmost column.
module sprite_rom_ch
  import sprite_pixel_engine_pkg::*;
#(
  parameter int SPR_W  = 16,
  parameter int ADDR_W = 10,
  parameter int CH_ID  = 0,
  parameter int N_FRM  = 4,
  parameter int ACT_W  = 3,
  parameter int FW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [SPR_W-1:0]  data_o
);
  localparam int ROW_W = ADDR_W - ACT_W - FW;

  logic [ROW_W-1:0] row;
  logic [ACT_W-1:0] act;
  logic [FW-1:0]    frm;
  int               r, a, f;
  logic [SPR_W-1:0] data_d, data_q;

  assign {row, act, frm} = addr_i;
  assign r = int'(row);
  assign a = int'(act);
  assign f = int'(frm);

  // 0 = body drawn; top row keeps its rightmost four columns clear.
  always_comb begin
    data_d = '1;
    if (a <= int'(ACT_KICK) && f < N_FRM) begin
      for (int c = 0; c < SPR_W; c++)
        data_d[SPR_W-1-c] = !((r != 0 || c < SPR_W - 4) &&
                              (((c + 2 * r + a + 3 * f + CH_ID) % 7) != 0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '1;
    else        data_q <= data_d;
  end

  assign data_o = data_q;
endmodule

// File: rtl/sprite_pixel_engine.sv
// Fighter sprite: animation sequencer on the frame strobe plus a 2-stage pixel hit/colour pipeline.
module sprite_pixel_engine
  import sprite_pixel_engine_pkg::*;
#(
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 16,
  parameter int N_ACT       = 8,
  parameter int N_FRM       = 4,
  parameter int CHANNELS    = 3,
  parameter int SCALE_LOG2  = 1,
  parameter int FRAME_TICKS = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick_i,
  input  logic [$clog2(N_ACT)-1:0] act_req_i,
  input  logic                     act_valid_i,
  input  logic                     mirror_i,
  input  logic [9:0]               spr_x_i,
  input  logic [9:0]               spr_y_i,
  output logic                     busy_o,
  output logic                     act_done_o,
  sprite_pixel_engine_if.slave     pix
);
  localparam int ACT_W  = $clog2(N_ACT);
  localparam int ROW_W  = $clog2(SPR_H);
  localparam int COL_W  = $clog2(SPR_W);
  localparam int ADDR_W = ROW_W + ACT_W + FRM_W;
  localparam int TCNT_W = $clog2(FRAME_TICKS + 1);
  localparam int STAGES = 2;

  st_e              state_q;
  logic [ACT_W-1:0] act_q, pend_q, apply_act;
  logic [FRM_W-1:0] frm_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic             pend_vld_q, busy_q, done_q;

  // A same-cycle request bypasses the pending register so it lands on this tick.
  assign apply_act = act_valid_i ? act_req_i : pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOOP;
      act_q      <= ACT_W'(ACT_STAY);
      frm_q      <= '0;
      tcnt_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_LOOP && act_valid_i) begin
        pend_q     <= act_req_i;
        pend_vld_q <= 1'b1;
      end
      if (tick_i) begin
        if (state_q == ST_LOOP && (act_valid_i || pend_vld_q)) begin
          act_q      <= apply_act;
          frm_q      <= '0;
          tcnt_q     <= '0;
          pend_vld_q <= 1'b0;
          if (is_oneshot(int'(apply_act))) begin
            state_q <= ST_ONESHOT;
            busy_q  <= 1'b1;
          end
        end else if (tcnt_q == TCNT_W'(FRAME_TICKS - 1)) begin
          tcnt_q <= '0;
          if (frm_q == FRM_W'(N_FRM - 1)) begin
            frm_q <= '0;
            if (state_q == ST_ONESHOT) begin
              state_q <= ST_LOOP;
              act_q   <= ACT_W'(ACT_STAY);
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            frm_q <= frm_q + 1'b1;
          end
        end else begin
          tcnt_q <= tcnt_q + 1'b1;
        end
      end
    end
  end

  assign busy_o     = busy_q;
  assign act_done_o = done_q;

  // Stage 1: box test on 11-bit differences (bit 10 set = pixel left of / above sprite).
  logic [10:0]       dx, dy;
  logic              hit_d;
  logic [COL_W-1:0]  col_raw, col_d;
  logic [ROW_W-1:0]  row_d;

  assign dx      = {1'b0, pix.pix_x} - {1'b0, spr_x_i};
  assign dy      = {1'b0, pix.pix_y} - {1'b0, spr_y_i};
  assign hit_d   = pix.pix_in_vld & ~dx[10] & ~dy[10] &
                   (dx < 11'(SPR_W << SCALE_LOG2)) & (dy < 11'(SPR_H << SCALE_LOG2));
  assign col_raw = dx[SCALE_LOG2 +: COL_W];
  assign col_d   = mirror_i ? COL_W'(SPR_W - 1) - col_raw : col_raw;
  assign row_d   = dy[SCALE_LOG2 +: ROW_W];

  logic [STAGES:1]   vld_pipe_q;
  logic              hit1_q, hit2_q;
  logic [COL_W-1:0]  col1_q, col2_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      col1_q     <= '0;
      col2_q     <= '0;
      addr_q     <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], pix.pix_in_vld};
      hit1_q     <= hit_d;
      hit2_q     <= hit1_q;
      col1_q     <= col_d;
      col2_q     <= col1_q;
      addr_q     <= {row_d, act_q, frm_q};
    end
  end

  logic [CHANNELS-1:0][SPR_W-1:0] rom_data;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    sprite_rom_ch #(
      .SPR_W(SPR_W), .ADDR_W(ADDR_W), .CH_ID(g),
      .N_FRM(N_FRM), .ACT_W(ACT_W), .FW(FRM_W)
    ) u_rom (
      .clk(clk), .rst_n(rst_n), .addr_i(addr_q), .data_o(rom_data[g])
    );
  end

  // Stage 2: pick the column bit out of each registered row.
  logic [CHANNELS-1:0] rgb;
  always_comb begin
    rgb = '0;
    if (hit2_q)
      for (int c = 0; c < CHANNELS; c++)
        rgb[c] = ~rom_data[c][COL_W'(SPR_W - 1) - col2_q];
  end

  assign pix.pix_rgb     = rgb;
  assign pix.pix_opaque  = |rgb;
  assign pix.pix_out_vld = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_sprite_pixel_engine.sv
// Self-checking bench: behavioural animation model, pixel scoreboard, hit-test vector table.
module tb_sprite_pixel_engine;
  localparam int SPR_W = 16, SPR_H = 16, N_ACT = 8, N_FRM = 4, CHANNELS = 3;
  localparam int SCALE_LOG2 = 1, FRAME_TICKS = 6;
  localparam logic [2:0] A_STAY = 3'd0, A_FWD = 3'd1, A_BACK = 3'd2, A_PUNCH = 3'd3, A_KICK = 3'd4;

  logic clk = 1'b0, rst_n = 1'b1;
  logic tick = 1'b0, act_valid = 1'b0, mirror = 1'b0;
  logic [2:0] act_req = '0;
  logic [9:0] spr_x = 10'd100, spr_y = 10'd50;
  logic busy, act_done;

  sprite_pixel_engine_if #(.CHANNELS(CHANNELS)) pif();

  sprite_pixel_engine #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .N_ACT(N_ACT), .N_FRM(N_FRM), .CHANNELS(CHANNELS),
    .SCALE_LOG2(SCALE_LOG2), .FRAME_TICKS(FRAME_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .act_req_i(act_req), .act_valid_i(act_valid),
    .mirror_i(mirror), .spr_x_i(spr_x), .spr_y_i(spr_y), .busy_o(busy), .act_done_o(act_done),
    .pix(pif.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0, done_seen = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Animation model
  int m_act, m_frm, m_tcnt, m_pend;
  bit m_pvld, m_one, m_done;

  task automatic model_reset();
    m_act = 0; m_frm = 0; m_tcnt = 0; m_pend = 0; m_pvld = 0; m_one = 0; m_done = 0;
  endtask

  task automatic model_update(input bit tk, input bit av, input int rq);
    m_done = 0;
    if (!m_one && av) begin m_pend = rq; m_pvld = 1; end
    if (tk) begin
      if (!m_one && m_pvld) begin
        m_act = m_pend; m_frm = 0; m_tcnt = 0; m_pvld = 0;
        m_one = (m_act == 3 || m_act == 4);
      end else begin
        m_tcnt++;
        if (m_tcnt == FRAME_TICKS) begin
          m_tcnt = 0;
          m_frm++;
          if (m_frm == N_FRM) begin
            m_frm = 0;
            if (m_one) begin m_one = 0; m_act = 0; m_done = 1; end
          end
        end
      end
    end
  endtask

  function automatic bit drawn(int ch, int r, int c, int a, int f);
    if (a > 4 || f >= N_FRM) return 0;
    if (r == 0 && c >= 12) return 0;
    return ((c + 2 * r + a + 3 * f + ch) % 7) != 0;
  endfunction

  typedef struct { int cyc; logic [2:0] rgb; logic opq; } exp_t;
  exp_t sbq[$];

  function automatic exp_t exp_pix(int px, int py, int sx, int sy, bit mir, bit hit);
    exp_t e;
    int c, r;
    e.cyc = cyc + 2; e.rgb = '0;
    if (hit) begin
      c = (px - sx) / 2; r = (py - sy) / 2;
      if (mir) c = 15 - c;
      for (int ch = 0; ch < 3; ch++) e.rgb[ch] = drawn(ch, r, c, m_act, m_frm);
    end
    e.opq = |e.rgb;
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (pif.pix_out_vld === 1'b1) begin
      if (sbq.size() == 0) chk("pix_out_vld unexpected", pif.pix_out_vld, 0);
      else begin
        e = sbq.pop_front();
        chk("pix latency", cyc, e.cyc);
        chk("pix_rgb", pif.pix_rgb, e.rgb);
        chk("pix_opaque", pif.pix_opaque, e.opq);
      end
    end else begin
      if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        chk("pix_out_vld missing", pif.pix_out_vld, 1);
        void'(sbq.pop_front());
      end
      chk("idle pixel outputs", {pif.pix_rgb, pif.pix_opaque}, 0);
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input bit tk, input bit av, input logic [2:0] rq,
                      input bit pv, input int px, input int py, input bit mir, input bit hit);
    tick = tk; act_valid = av; act_req = rq; mirror = mir;
    pif.pix_in_vld = pv; pif.pix_x = 10'(px); pif.pix_y = 10'(py);
    if (pv) sbq.push_back(exp_pix(px, py, int'(spr_x), int'(spr_y), mir, hit));
    @(posedge clk); #1;
    model_update(tk, av, int'(rq));
    tick = 0; act_valid = 0; pif.pix_in_vld = 0;
    chk("busy", busy, m_one);
    chk("act_done", act_done, m_done);
    if (act_done) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 3'd0, 0, 0, 0, 0, 0);
  endtask

  // Three in-box pixels whose colours depend on action and frame.
  task automatic probe();
    spr_x = 10'd100; spr_y = 10'd50;
    step(0, 0, 3'd0, 1, 100, 50, 0, 1);
    step(0, 0, 3'd0, 1, 110, 54, 0, 1);
    step(0, 0, 3'd0, 1, 121, 62, 1, 1);
    idle(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #1;
    chk("reset busy", busy, 0);
    chk("reset act_done", act_done, 0);
    chk("reset pix_out_vld", pif.pix_out_vld, 0);
    chk("reset pixel", {pif.pix_rgb, pif.pix_opaque}, 0);
    sbq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct { int px, py, sx, sy; bit mir; bit hit; } vec_t;
  vec_t vt[14];

  initial begin : wdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    vt[0]  = '{100, 50, 100, 50, 1'b0, 1'b1};
    vt[1]  = '{ 99, 50, 100, 50, 1'b0, 1'b0};
    vt[2]  = '{131, 81, 100, 50, 1'b0, 1'b1};
    vt[3]  = '{132, 50, 100, 50, 1'b0, 1'b0};
    vt[4]  = '{100, 49, 100, 50, 1'b0, 1'b0};
    vt[5]  = '{100, 82, 100, 50, 1'b0, 1'b0};
    vt[6]  = '{131, 50, 100, 50, 1'b0, 1'b1};
    vt[7]  = '{100, 50, 100, 50, 1'b1, 1'b1};
    vt[8]  = '{117, 63, 100, 50, 1'b1, 1'b1};
    vt[9]  = '{  5,  5, 1000, 470, 1'b0, 1'b0};
    vt[10] = '{  0,  0,   0,   0, 1'b0, 1'b1};
    vt[11] = '{ 31, 31,   0,   0, 1'b1, 1'b1};
    vt[12] = '{1023, 479, 1000, 470, 1'b0, 1'b1};
    vt[13] = '{1023, 50, 100, 50, 1'b0, 1'b0};

    pif.pix_x = '0; pif.pix_y = '0; pif.pix_in_vld = 1'b0;
    model_reset();
    #2 do_reset();

    // Looping STAY animation: frame steps every FRAME_TICKS strobes.
    idle(2);
    probe();
    for (int i = 1; i <= 13; i++) begin
      step(1, 0, 3'd0, 0, 0, 0, 0, 0);
      if (i == 6 || i == 12 || i == 13) probe();
    end

    // Hit-test table, including box edges, mirroring and negative offsets.
    for (int i = 0; i < 14; i++) begin
      spr_x = 10'(vt[i].sx); spr_y = 10'(vt[i].sy);
      step(0, 0, 3'd0, 1, vt[i].px, vt[i].py, vt[i].mir, vt[i].hit);
    end
    idle(3);

    // One-shot punch: held until tick, FWD ignored while busy, single done pulse.
    step(0, 1, A_PUNCH, 0, 0, 0, 0, 0);
    idle(3);
    probe();
    step(1, 0, 3'd0, 0, 0, 0, 0, 0);
    chk("busy after punch tick", busy, 1);
    probe();
    d0 = done_seen;
    for (int i = 1; i <= 24; i++) begin
      step(1, (i == 3), A_FWD, 0, 0, 0, 0, 0);
      if (i == 6 || i == 12 || i == 18) probe();
    end
    chk("act_done pulse count", done_seen - d0, 1);
    chk("busy after one-shot", busy, 0);
    probe();
    tick_n(2);
    probe();

    // FWD together with tick applies on that tick; last pending request wins.
    step(1, 1, A_FWD, 0, 0, 0, 0, 0);
    probe();
    tick_n(6);
    probe();
    step(0, 1, A_PUNCH, 0, 0, 0, 0, 0);
    step(0, 1, A_BACK, 0, 0, 0, 0, 0);
    step(1, 0, 3'd0, 0, 0, 0, 0, 0);
    chk("busy after BACK overrides PUNCH", busy, 0);
    probe();

    // Reset during a kick at frame 2 with a pixel in flight.
    step(1, 1, A_KICK, 0, 0, 0, 0, 0);
    tick_n(14);
    probe();
    step(0, 0, 3'd0, 1, 100, 50, 0, 1);
    do_reset();
    d0 = done_seen;
    tick_n(30);
    chk("act_done after aborted one-shot", done_seen - d0, 0);
    probe();

    idle(3);
    chk("scoreboard drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
